// File: rtl/apb_intc_slave.sv
// APB responder for the interrupt-controller slot.
// Peripheral interrupt lines are captured into pending bits, using edge or
// level detection per line, and masked by an enable register. A single
// registered irq_out goes to the CPU. Each access waits WAIT_STATES cycles
// before pready, and unknown offsets or writes to read-only registers
// complete with pslverr.
module apb_intc_slave #(
    parameter int NUM_IRQ     = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        paddr,
    input  logic               pwrite,
    input  logic               psel,
    input  logic               penable,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    // Register bits at or above NUM_IRQ always read 0 and ignore writes.
    localparam logic [31:0] IRQ_MASK  = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << NUM_IRQ) - 32'd1);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);

    // Word offsets, decoded from paddr[7:2].
    localparam logic [5:0] W_STATUS  = 6'h00;
    localparam logic [5:0] W_PENDING = 6'h01;
    localparam logic [5:0] W_ENABLE  = 6'h02;
    localparam logic [5:0] W_CLEAR   = 6'h03;
    localparam logic [5:0] W_SET     = 6'h04;
    localparam logic [5:0] W_EDGE    = 6'h05;
    localparam logic [5:0] W_ID      = 6'h06;

    logic [3:0]  wcnt;
    logic        access;
    logic [5:0]  word;
    logic [31:0] irq_ext;
    logic [31:0] irq_q;
    logic [31:0] pending;
    logic [31:0] enable;
    logic [31:0] edge_sel;
    logic [31:0] status;
    logic [31:0] id_value;
    logic [31:0] rd_value;
    logic        known;
    logic        read_only;
    logic        illegal;
    logic        wr_commit;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] hw_event;
    logic [31:0] pending_next;
    logic [31:0] enable_next;
    logic [31:0] edge_next;
    logic        unused_paddr;

    // Index of the lowest set bit, 0 when no bit is set.
    function automatic logic [4:0] lowest_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    assign access       = psel & penable;
    assign word         = paddr[7:2];
    assign irq_ext      = 32'(irq_in) & IRQ_MASK;
    assign unused_paddr = ^{paddr[31:8], paddr[1:0]};

    assign status   = pending & enable;
    assign id_value = {(|status), 26'd0, lowest_index(status)};

    // Address decode: read mux, legality and read-only classification.
    always_comb begin
        known     = 1'b1;
        read_only = 1'b0;
        rd_value  = 32'd0;
        case (word)
            W_STATUS:  begin rd_value = status;   read_only = 1'b1; end
            W_PENDING: begin rd_value = pending;  read_only = 1'b1; end
            W_ENABLE:  rd_value = enable;
            W_CLEAR:   rd_value = 32'd0;
            W_SET:     rd_value = 32'd0;
            W_EDGE:    rd_value = edge_sel;
            W_ID:      begin rd_value = id_value; read_only = 1'b1; end
            default:   known = 1'b0;
        endcase
        illegal = ~known | (pwrite & read_only);
    end

    assign pready    = access & (wcnt == WAIT_LAST);
    assign pslverr   = pready & illegal;
    assign prdata    = (pready & ~illegal) ? rd_value : 32'd0;
    assign wr_commit = pready & pwrite & ~illegal;

    // Next-state of the software-visible registers and pending bits.
    always_comb begin
        set_mask    = 32'd0;
        clr_mask    = 32'd0;
        enable_next = enable;
        edge_next   = edge_sel;
        if (wr_commit) begin
            case (word)
                W_ENABLE: enable_next = pwdata & IRQ_MASK;
                W_CLEAR:  clr_mask    = pwdata & IRQ_MASK;
                W_SET:    set_mask    = pwdata & IRQ_MASK;
                W_EDGE:   edge_next   = pwdata & IRQ_MASK;
                default:  ;
            endcase
        end
        // Edge lines fire on a rising edge, level lines while high.
        hw_event     = ((irq_ext & ~irq_q) & edge_sel) | (irq_ext & ~edge_sel);
        // Set and hardware events win over a clear of the same bit.
        pending_next = ((pending & ~clr_mask) | hw_event | set_mask) & IRQ_MASK;
    end

    // Wait-state counter: runs only inside an access phase, clears on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= 4'd0;
        end else if (!access || pready) begin
            wcnt <= 4'd0;
        end else begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Register file and pending state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 32'd0;
            enable   <= 32'd0;
            edge_sel <= 32'd0;
        end else begin
            pending  <= pending_next;
            enable   <= enable_next;
            edge_sel <= edge_next;
        end
    end

    // Input history for edge detection and the registered combined interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= 32'd0;
            irq_out <= 1'b0;
        end else begin
            irq_q   <= irq_ext;
            irq_out <= |(pending_next & enable_next);
        end
    end

endmodule

// File: tb/tb_apb_intc_slave.sv
// Directed bench for apb_intc_slave: table-driven register accesses plus
// hand-written sequences for interrupt, clear/set races, aborts and reset.
module tb_apb_intc_slave;

    localparam int NUM_IRQ     = 16;
    localparam int WAIT_STATES = 1;

    localparam logic [31:0] A_STATUS  = 32'h00;
    localparam logic [31:0] A_PENDING = 32'h04;
    localparam logic [31:0] A_ENABLE  = 32'h08;
    localparam logic [31:0] A_CLEAR   = 32'h0C;
    localparam logic [31:0] A_SET     = 32'h10;
    localparam logic [31:0] A_EDGE    = 32'h14;
    localparam logic [31:0] A_ID      = 32'h18;

    logic               clk;
    logic               reset;
    logic [31:0]        paddr;
    logic               pwrite;
    logic               psel;
    logic               penable;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq_out;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] rd_d;
    logic        er;
    int          w;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl[NVEC];

    apb_intc_slave #(
        .NUM_IRQ    (NUM_IRQ),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .paddr  (paddr),
        .pwrite (pwrite),
        .psel   (psel),
        .penable(penable),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .irq_in (irq_in),
        .irq_out(irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; pulse bits are raised during the completing cycle so
    // that they are sampled on the same edge that commits the write.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [NUM_IRQ-1:0] pulse,
                       output logic [31:0] rdata, output logic err, output int waits);
        bit got;
        got   = 0;
        waits = 0;
        rdata = 32'd0;
        err   = 1'b0;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        tick();
        penable = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pready) begin
                got    = 1;
                rdata  = prdata;
                err    = pslverr;
                irq_in = irq_in | pulse;
            end else begin
                waits++;
                tick();
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL apb_timeout addr=%h no pready", addr);
        end
        tick();
        psel = 1'b0; penable = 1'b0;
        irq_in = irq_in & ~pulse;
    endtask

    task automatic do_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        apb(1'b0, a, 32'd0, '0, rd_d, er, w);
        check(nm, rd_d, exp);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
        apb(1'b1, a, d, '0, rd_d, er, w);
        check("wr_err", 32'(er), 32'd0);
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; irq_in = '0;

        tbl[0]  = '{1'b1, A_ENABLE,      32'h0000_0005, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, A_EDGE,        32'h0000_0001, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, A_ENABLE,      32'h0,         32'h0000_0005, 1'b0};
        tbl[3]  = '{1'b0, A_EDGE,        32'h0,         32'h0000_0001, 1'b0};
        tbl[4]  = '{1'b0, 32'h40,        32'h0,         32'h0, 1'b1};
        tbl[5]  = '{1'b1, A_STATUS,      32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, A_PENDING,     32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, A_ID,          32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, A_CLEAR,       32'h0,         32'h0, 1'b0};
        tbl[9]  = '{1'b0, A_SET,         32'h0,         32'h0, 1'b0};
        tbl[10] = '{1'b0, A_PENDING,     32'h0,         32'h0, 1'b0};
        tbl[11] = '{1'b1, A_ENABLE,      32'hFFFF_FFFF, 32'h0, 1'b0};
        tbl[12] = '{1'b0, A_ENABLE,      32'h0,         32'h0000_FFFF, 1'b0};
        tbl[13] = '{1'b1, A_ENABLE,      32'h0000_0005, 32'h0, 1'b0};
        tbl[14] = '{1'b0, A_ENABLE,      32'h0,         32'h0000_0005, 1'b0};
        tbl[15] = '{1'b0, A_STATUS,      32'h0,         32'h0, 1'b0};
        tbl[16] = '{1'b0, 32'h1C,        32'h0,         32'h0, 1'b1};
        tbl[17] = '{1'b1, 32'h3C,        32'h1234_5678, 32'h0, 1'b1};
        tbl[18] = '{1'b0, 32'h0000_010A, 32'h0,         32'h0000_0005, 1'b0};
        tbl[19] = '{1'b0, A_ID,          32'h0,         32'h0, 1'b0};

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_pready",  32'(pready),  32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata",  prdata,       32'd0);
        check("rst_irq_out", 32'(irq_out), 32'd0);

        // First read after reset: one wait cycle, data 0
        apb(1'b0, A_ENABLE, 32'd0, '0, rd_d, er, w);
        check("first_rd_waits", 32'(w), 32'd1);
        check("first_rd_data",  rd_d,   32'd0);
        check("first_rd_err",   32'(er), 32'd0);
        check("first_irq_out",  32'(irq_out), 32'd0);

        // Register map vectors
        for (int i = 0; i < NVEC; i++) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, '0, rd_d, er, w);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_waits", i), 32'(w), 32'd1);
            if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd_d, tbl[i].exp_rdata);
        end

        // Edge interrupt on line 0 (ENABLE=5, EDGE_SEL=1)
        irq_in[0] = 1'b1;
        check("edge_irq_before", 32'(irq_out), 32'd0);
        tick();
        irq_in[0] = 1'b0;
        check("edge_irq_after", 32'(irq_out), 32'd1);
        repeat (2) tick();
        do_rd("edge_pending", A_PENDING, 32'h1);
        do_rd("edge_status",  A_STATUS,  32'h1);
        do_rd("edge_id",      A_ID,      32'h8000_0000);
        do_wr(A_CLEAR, 32'h1);
        check("edge_clr_irq", 32'(irq_out), 32'd0);
        do_rd("edge_clr_pending", A_PENDING, 32'h0);

        // Level interrupt on line 2 re-pends while held high
        irq_in[2] = 1'b1;
        tick();
        check("lvl_irq", 32'(irq_out), 32'd1);
        do_rd("lvl_pending", A_PENDING, 32'h4);
        do_rd("lvl_id",      A_ID,      32'h8000_0002);
        do_wr(A_CLEAR, 32'h4);
        check("lvl_clr_irq_held", 32'(irq_out), 32'd1);
        do_rd("lvl_clr_pending_held", A_PENDING, 32'h4);
        irq_in[2] = 1'b0;
        do_wr(A_CLEAR, 32'h4);
        check("lvl_clr_irq_low", 32'(irq_out), 32'd0);
        do_rd("lvl_clr_pending_low", A_PENDING, 32'h0);

        // Changing EDGE_SEL leaves pending bits alone
        do_wr(A_SET, 32'h2);
        do_wr(A_EDGE, 32'h3);
        do_rd("edgesel_keeps_pending", A_PENDING, 32'h2);
        check("masked_irq_low", 32'(irq_out), 32'd0);
        do_wr(A_CLEAR, 32'h2);

        // Rising edge on line 3 in the same cycle that CLEAR commits
        do_wr(A_EDGE, 32'h9);
        do_wr(A_SET, 32'h8);
        do_rd("set_pending", A_PENDING, 32'h8);
        apb(1'b1, A_CLEAR, 32'h8, 16'h0008, rd_d, er, w);
        do_rd("race_pending", A_PENDING, 32'h8);
        do_wr(A_CLEAR, 32'h8);
        do_rd("race_clr_pending", A_PENDING, 32'h0);

        // Aborted write: psel dropped during the wait cycle
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_ENABLE; pwdata = 32'hAA;
        tick();
        penable = 1'b1;
        @(negedge clk);
        check("abort_pready_wait", 32'(pready), 32'd0);
        tick();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_pready_after", 32'(pready), 32'd0);
        apb(1'b0, A_ENABLE, 32'd0, '0, rd_d, er, w);
        check("abort_enable", rd_d, 32'h5);
        check("abort_next_waits", 32'(w), 32'd1);

        // Reset asserted during the wait cycle of a write
        do_wr(A_SET, 32'h1);
        check("pre_rst_irq", 32'(irq_out), 32'd1);
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_ENABLE; pwdata = 32'h3;
        tick();
        penable = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("rst_wait_pready", 32'(pready), 32'd0);
        tick();
        psel = 1'b0; penable = 1'b0; reset = 1'b0;
        check("rst_wait_irq", 32'(irq_out), 32'd0);
        apb(1'b0, A_ENABLE, 32'd0, '0, rd_d, er, w);
        check("rst_wait_enable", rd_d, 32'h0);
        check("rst_wait_waits", 32'(w), 32'd1);
        do_rd("rst_wait_pending", A_PENDING, 32'h0);
        do_rd("rst_wait_edge",    A_EDGE,    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
